tone_sequencer: RTL and testbench

//  Schedules the I2S square-wave tone generator. Buffers a queue of notes (period, duration)

---
 rtl/tone_pkg.sv | 18 +
 rtl/note_fifo.sv | 55 +++++
 rtl/tone_sequencer.sv | 139 +++++++++++++
 tb/tb_tone_sequencer.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tone_pkg.sv
// Shared types for the tone sequencer: note record and sequencer state.
package tone_pkg;

  localparam int unsigned PERIOD_W   = 16;
  localparam int unsigned NOTE_DUR_W = 16;

  typedef struct packed {
    logic [PERIOD_W-1:0]   period;
    logic [NOTE_DUR_W-1:0] dur;
  } note_t;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    PLAY
  } state_t;

endpackage

// File: rtl/note_fifo.sv
// Synchronous note FIFO with occupancy output and synchronous flush.
module note_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned W     = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             rdata,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [LW-1:0] level_q;
  logic          push_ok, pop_ok;

  assign full    = (level_q == LW'(DEPTH));
  assign push_ok = push & ~full & ~flush;
  assign pop_ok  = pop & (level_q != '0) & ~flush;
  assign rdata   = mem_q[rptr_q];
  assign level   = level_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else if (flush) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + AW'(1);
      if (pop_ok)  rptr_q <= rptr_q + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q] <= wdata;
  end

endmodule

// File: rtl/tone_sequencer.sv
// Plays a queue of (period, duration) notes into the I2S tone generator,
// timing each note in generator LR frames.
module tone_sequencer
  import tone_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned DUR_W = NOTE_DUR_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  input  logic [15:0]            wr_period,
  input  logic [DUR_W-1:0]       wr_dur,
  input  logic                   start,
  input  logic                   stop,
  input  logic                   lrclk,
  output logic [15:0]            period,
  output logic                   mute,
  output logic                   busy,
  output logic                   done,
  output logic [$clog2(DEPTH):0] level
);

  localparam int unsigned LW     = $clog2(DEPTH) + 1;
  localparam int unsigned NOTE_W = PERIOD_W + DUR_W;

  state_t           state_q, state_d;
  logic [DUR_W-1:0] cnt_q, cnt_d;
  logic [15:0]      period_q, period_d;
  logic             mute_q, mute_d;
  logic             done_q, done_d;
  logic             lrclk_q;
  logic             tick;

  logic              fifo_full, fifo_push, fifo_pop;
  logic [NOTE_W-1:0] head;
  logic [15:0]       head_period;
  logic [DUR_W-1:0]  head_dur;

  assign fifo_push   = wr_valid & ~fifo_full & ~stop;
  assign head_period = head[NOTE_W-1 -: PERIOD_W];
  assign head_dur    = head[DUR_W-1:0];

  note_fifo #(
    .DEPTH (DEPTH),
    .W     (NOTE_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (reset),
    .flush (stop),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata ({wr_period, wr_dur}),
    .rdata (head),
    .full  (fifo_full),
    .level (level)
  );

  assign tick     = lrclk & ~lrclk_q;
  assign wr_ready = ~fifo_full;
  assign period   = period_q;
  assign mute     = mute_q;
  assign busy     = (state_q != IDLE);
  assign done     = done_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      period_q <= '0;
      mute_q   <= 1'b1;
      done_q   <= 1'b0;
      lrclk_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      mute_q   <= mute_d;
      done_q   <= done_d;
      lrclk_q  <= lrclk;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    period_d = period_q;
    mute_d   = mute_q;
    done_d   = 1'b0;
    fifo_pop = 1'b0;
    if (stop) begin
      state_d = IDLE;
      mute_d  = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          mute_d = 1'b1;
          if (start) begin
            if (level != '0) state_d = LOAD;
            else             done_d  = 1'b1;
          end
        end
        LOAD: begin
          fifo_pop = 1'b1;
          // zero-length notes are consumed back-to-back without touching the outputs
          if (head_dur == '0) begin
            if (level <= LW'(1)) begin
              state_d = IDLE;
              mute_d  = 1'b1;
              done_d  = 1'b1;
            end
          end else begin
            period_d = head_period;
            mute_d   = (head_period == '0);
            cnt_d    = head_dur;
            state_d  = PLAY;
          end
        end
        PLAY: begin
          if (tick) begin
            if (cnt_q != '0) cnt_d = cnt_q - DUR_W'(1);
            if (cnt_q == DUR_W'(1)) begin
              if (level != '0) begin
                state_d = LOAD;
              end else begin
                state_d = IDLE;
                mute_d  = 1'b1;
                done_d  = 1'b1;
              end
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tone_sequencer.sv
// Scoreboard bench for tone_sequencer: note events and done pulses are
// predicted from the queued notes and checked by an independent monitor.
module tb_tone_sequencer;
  import tone_pkg::*;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned DUR_W = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              wr_valid, wr_ready;
  logic [15:0]       wr_period;
  logic [DUR_W-1:0]  wr_dur;
  logic              start, stop, lrclk;
  logic [15:0]       period;
  logic              mute, busy, done;
  logic [3:0]        level;

  tone_sequencer #(
    .DEPTH (DEPTH),
    .DUR_W (DUR_W)
  ) dut (
    .clk       (clk),
    .reset     (rst_n),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_period (wr_period),
    .wr_dur    (wr_dur),
    .start     (start),
    .stop      (stop),
    .lrclk     (lrclk),
    .period    (period),
    .mute      (mute),
    .busy      (busy),
    .done      (done),
    .level     (level)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_done;
    logic [15:0] period;
    logic        mute;
    int          dur;
  } ev_t;

  int          n_cmp = 0;
  int          n_bad = 0;
  bit          mon_en = 1'b0;
  ev_t         exp_q[$];
  note_t       mq[$];
  logic [15:0] held_period = 16'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // LR clock: rising edge every 6 system clocks
  initial begin
    lrclk = 1'b0;
    forever begin
      repeat (3) @(posedge clk);
      #1 lrclk = ~lrclk;
    end
  end

  // Monitor: a note event is any visible change of {period,mute} while busy
  initial begin : monitor
    logic [16:0] prev_vis;
    bit          lr_prev, have_note;
    int          ticks, cur_dur;
    ev_t         e;
    prev_vis = '0; lr_prev = 1'b0; have_note = 1'b0; ticks = 0; cur_dur = 0;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        have_note = 1'b0;
      end else if (done || (busy && {period, mute} != prev_vis)) begin
        if (have_note) check("note_ticks", 32'(ticks), 32'(cur_dur));
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_event: done=%0b period=%0h mute=%0b, none expected", done, period, mute);
          have_note = 1'b0;
        end else begin
          e = exp_q.pop_front();
          check("event_is_done", 32'(done), 32'(e.is_done));
          if (!e.is_done && !done) begin
            check("note_period", 32'(period), 32'(e.period));
            check("note_mute", 32'(mute), 32'(e.mute));
            have_note = 1'b1;
            cur_dur   = e.dur;
          end else begin
            have_note = 1'b0;
          end
        end
        ticks = 0;
      end
      if (lrclk && !lr_prev) ticks++;
      lr_prev  = lrclk;
      prev_vis = {period, mute};
    end
  end

  task automatic write_note(input logic [15:0] p, input logic [DUR_W-1:0] d);
    note_t nt;
    check("wr_ready", 32'(wr_ready), 32'(mq.size() < DEPTH));
    wr_valid = 1'b1; wr_period = p; wr_dur = d;
    @(posedge clk);
    #1 wr_valid = 1'b0;
    if (mq.size() < DEPTH) begin
      nt.period = p;
      nt.dur    = d;
      mq.push_back(nt);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Reference: playing the queue yields one event per non-zero-length note, then done
  task automatic model_start();
    ev_t e;
    foreach (mq[i]) begin
      if (mq[i].dur != '0) begin
        e.is_done = 1'b0;
        e.period  = mq[i].period;
        e.mute    = (mq[i].period == 16'd0);
        e.dur     = int'(mq[i].dur);
        exp_q.push_back(e);
        held_period = mq[i].period;
      end
    end
    e.is_done = 1'b1; e.period = '0; e.mute = 1'b1; e.dur = 0;
    exp_q.push_back(e);
    mq.delete();
  endtask

  task automatic wait_idle();
    int cyc;
    cyc = 0;
    while (busy && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    if (busy) check("idle_timeout", 32'(busy), 32'(0));
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Consecutive played notes are made visibly distinct, and zero-length runs kept short
  task automatic gen_and_write(input int n, input bit no_skip);
    logic [16:0]      vis;
    logic [15:0]      p;
    logic [DUR_W-1:0] d;
    int               zrun;
    vis  = {held_period, 1'b1};
    zrun = 0;
    for (int i = 0; i < n; i++) begin
      if (!no_skip && zrun < 2 && $urandom_range(0, 3) == 0) d = '0;
      else d = DUR_W'($urandom_range(1, 3));
      do begin
        if ($urandom_range(0, 3) == 0) p = '0;
        else p = 16'($urandom_range(1, 65535));
      end while (d != '0 && {p, (p == 16'd0)} == vis);
      if (d != '0) begin
        vis  = {p, (p == 16'd0)};
        zrun = 0;
      end else begin
        zrun++;
      end
      write_note(p, d);
    end
  endtask

  initial begin
    int done_seen, busy_seen;
    rst_n = 1'b0; wr_valid = 1'b0; wr_period = '0; wr_dur = '0;
    start = 1'b0; stop = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_period", 32'(period), 32'(0));
    check("rst_mute", 32'(mute), 32'(1));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_done", 32'(done), 32'(0));
    check("rst_wr_ready", 32'(wr_ready), 32'(1));
    check("rst_level", 32'(level), 32'(0));
    rst_n = 1'b1;
    @(posedge clk);
    #1 mon_en = 1'b1;

    // basic play with latency check and an ignored start while busy
    write_note(16'd2, DUR_W'(3));
    write_note(16'd5, DUR_W'(1));
    check("level_two", 32'(level), 32'(2));
    model_start();
    pulse_start();
    @(posedge clk);
    #1;
    check("start_latency_period", 32'(period), 32'(2));
    check("start_latency_mute", 32'(mute), 32'(0));
    pulse_start();
    wait_idle();
    check("play_end_mute", 32'(mute), 32'(1));
    check("play_end_period", 32'(period), 32'(5));

    // rest and skip
    write_note(16'd0, DUR_W'(2));
    write_note(16'd7, DUR_W'(0));
    write_note(16'd9, DUR_W'(1));
    model_start();
    pulse_start();
    wait_idle();

    // full FIFO: ninth write dropped
    gen_and_write(8, 1'b0);
    check("full_level", 32'(level), 32'(8));
    write_note(16'h1234, DUR_W'(2));
    check("full_level_after_drop", 32'(level), 32'(8));
    model_start();
    pulse_start();
    @(posedge clk);
    #1;
    check("first_pop_level", 32'(level), 32'(7));
    check("first_pop_wr_ready", 32'(wr_ready), 32'(1));
    wait_idle();

    // stop mid-play with a concurrent write
    mon_en = 1'b0;
    for (int i = 1; i <= 5; i++) write_note(16'(100 * i), DUR_W'(3));
    mq.delete();
    pulse_start();
    @(posedge clk);
    #1;
    check("stop_pre_level", 32'(level), 32'(4));
    check("stop_pre_busy", 32'(busy), 32'(1));
    stop = 1'b1; wr_valid = 1'b1; wr_period = 16'd77; wr_dur = DUR_W'(2);
    @(posedge clk);
    #1 stop = 1'b0; wr_valid = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (i == 0) begin
        check("stop_level", 32'(level), 32'(0));
        check("stop_busy", 32'(busy), 32'(0));
        check("stop_mute", 32'(mute), 32'(1));
        check("stop_period_held", 32'(period), 32'(100));
      end
      if (done) done_seen++;
      @(posedge clk);
      #1;
    end
    check("stop_no_done", 32'(done_seen), 32'(0));
    check("stop_write_dropped", 32'(level), 32'(0));
    held_period = 16'd100;
    mon_en = 1'b1;

    // empty start: done only, never busy
    model_start();
    pulse_start();
    busy_seen = 0;
    for (int i = 0; i < 4; i++) begin
      if (busy) busy_seen++;
      @(posedge clk);
      #1;
    end
    check("empty_start_busy", 32'(busy_seen), 32'(0));

    // random batches
    for (int r = 0; r < 25; r++) begin
      gen_and_write($urandom_range(1, DEPTH), 1'b0);
      check("batch_level", 32'(level), 32'(mq.size()));
      model_start();
      pulse_start();
      wait_idle();
    end
    check("scoreboard_drained", 32'(exp_q.size()), 32'(0));

    // asynchronous reset mid-play
    mon_en = 1'b0;
    gen_and_write(3, 1'b1);
    mq.delete();
    pulse_start();
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("async_rst_period", 32'(period), 32'(0));
    check("async_rst_mute", 32'(mute), 32'(1));
    check("async_rst_busy", 32'(busy), 32'(0));
    check("async_rst_level", 32'(level), 32'(0));
    check("async_rst_wr_ready", 32'(wr_ready), 32'(1));
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
